// File: rtl/channel_voice_synth.sv
`timescale 1ns/1ps
// channel_voice_synth
//   Two-voice burst synthesiser driven by the channel sequencer trigger bus.
//   Each trigger bit starts (or restarts) a decaying square-wave burst on its
//   voice. The two voice levels are summed with saturation. A free-running
//   sample divider then captures the sum into a valid/ready output register
//   for the codec write path.
//
// Ports
//   clock         system clock
//   resetn        asynchronous active-low reset
//   playEn        1 = accept triggers, 0 = ignore new triggers (running bursts finish)
//   trig[1:0]     one-cycle step triggers, bit i starts voice i
//   sample[31:0]  signed mixed sample (two's complement), held while valid and not ready
//   sample_valid  sample register holds an unaccepted sample
//   sample_ready  codec can take a sample this cycle
//   active[1:0]   per-voice burst in progress
//   overrun       sticky: a sample tick arrived while the previous sample was unaccepted
module channel_voice_synth #(
    parameter int          HALF_PER0   = 113636,
    parameter int          HALF_PER1   = 56818,
    parameter int          BURST_LEN   = 5000000,
    parameter logic [31:0] AMP_INIT    = 32'h1000_0000,
    parameter int          DECAY_DIV   = 250000,
    parameter int          DECAY_SHIFT = 3,
    parameter int          SAMPLE_DIV  = 1042
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        playEn,
    input  logic [1:0]  trig,
    output logic [31:0] sample,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [1:0]  active,
    output logic        overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        RING = 1'b1
    } voice_state_t;

    logic signed [31:0] voice_level [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_voice
            localparam int HALF_PER = (gi == 0) ? HALF_PER0 : HALF_PER1;

            voice_state_t state_reg, state_next;
            logic [31:0]  amp_reg, amp_next;
            logic [31:0]  burst_cnt_reg, burst_cnt_next;
            logic [31:0]  half_cnt_reg, half_cnt_next;
            logic [31:0]  decay_cnt_reg, decay_cnt_next;
            logic         phase_reg, phase_next;
            logic         start;

            assign start = trig[gi] & playEn;

            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    state_reg     <= IDLE;
                    amp_reg       <= '0;
                    burst_cnt_reg <= '0;
                    half_cnt_reg  <= '0;
                    decay_cnt_reg <= '0;
                    phase_reg     <= 1'b1;
                end else begin
                    state_reg     <= state_next;
                    amp_reg       <= amp_next;
                    burst_cnt_reg <= burst_cnt_next;
                    half_cnt_reg  <= half_cnt_next;
                    decay_cnt_reg <= decay_cnt_next;
                    phase_reg     <= phase_next;
                end
            end

            always_comb begin
                state_next     = state_reg;
                amp_next       = amp_reg;
                burst_cnt_next = burst_cnt_reg;
                half_cnt_next  = half_cnt_reg;
                decay_cnt_next = decay_cnt_reg;
                phase_next     = phase_reg;
                // A trigger reloads everything from either state, so it also
                // takes priority over the end-of-burst condition.
                if (start) begin
                    state_next     = RING;
                    amp_next       = AMP_INIT;
                    burst_cnt_next = 32'(BURST_LEN - 1);
                    half_cnt_next  = 32'(HALF_PER - 1);
                    decay_cnt_next = 32'(DECAY_DIV - 1);
                    phase_next     = 1'b1;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            state_next = IDLE;
                        end
                        RING: begin
                            if (burst_cnt_reg == '0 || amp_reg == '0) begin
                                state_next = IDLE;
                            end else begin
                                burst_cnt_next = burst_cnt_reg - 32'd1;
                                if (half_cnt_reg == '0) begin
                                    half_cnt_next = 32'(HALF_PER - 1);
                                    phase_next    = ~phase_reg;
                                end else begin
                                    half_cnt_next = half_cnt_reg - 32'd1;
                                end
                                if (decay_cnt_reg == '0) begin
                                    decay_cnt_next = 32'(DECAY_DIV - 1);
                                    amp_next       = amp_reg - (amp_reg >> DECAY_SHIFT);
                                end else begin
                                    decay_cnt_next = decay_cnt_reg - 32'd1;
                                end
                            end
                        end
                        default: state_next = IDLE;
                    endcase
                end
            end

            assign active[gi]      = (state_reg == RING);
            assign voice_level[gi] = (state_reg != RING) ? 32'sd0 :
                                     (phase_reg ? $signed(amp_reg) : -$signed(amp_reg));
        end
    endgenerate

    // Mix in 33 bits; a disagreement between the top two bits means the
    // true sum does not fit in 32 bits, so clamp toward the sign of the sum.
    logic [32:0] mix_wide;
    logic [31:0] mix_sat;

    assign mix_wide = {voice_level[0][31], voice_level[0]} +
                      {voice_level[1][31], voice_level[1]};

    always_comb begin
        mix_sat = mix_wide[31:0];
        if (mix_wide[32] != mix_wide[31]) begin
            mix_sat = mix_wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    // Free-running sample divider, independent of voice activity.
    logic [31:0] tick_cnt_reg;
    logic        tick;

    assign tick = (tick_cnt_reg == 32'(SAMPLE_DIV - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 32'd1;
        end
    end

    // Output register: a tick only loads when the register is free or is
    // being emptied this very cycle; otherwise the new sample is dropped.
    logic [31:0] sample_reg;
    logic        valid_reg;
    logic        overrun_reg;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sample_reg  <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (valid_reg) begin
                if (sample_ready) begin
                    if (tick) begin
                        sample_reg <= mix_sat;
                    end else begin
                        valid_reg <= 1'b0;
                    end
                end else if (tick) begin
                    overrun_reg <= 1'b1;
                end
            end else if (tick) begin
                sample_reg <= mix_sat;
                valid_reg  <= 1'b1;
            end
        end
    end

    assign sample       = sample_reg;
    assign sample_valid = valid_reg;
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_channel_voice_synth.sv
`timescale 1ns/1ps
module tb_channel_voice_synth;

    localparam int          HP0  = 16;
    localparam int          HP1  = 8;
    localparam int          BL   = 64;
    localparam int          DD   = 32;
    localparam int          DS   = 3;
    localparam int          SD   = 8;
    localparam logic [31:0] AMP  = 32'd4096;
    localparam logic [31:0] AMPS = 32'h7FFF_FFFF;

    logic        clock = 1'b0;
    logic        resetn;
    logic        playEn;
    logic [1:0]  trig;
    logic        sample_ready;
    logic [31:0] sample;
    logic        sample_valid;
    logic [1:0]  active;
    logic        overrun;

    logic [1:0]  sat_trig;
    logic        sat_ready;
    logic [31:0] sat_sample;
    logic        sat_valid;
    logic [1:0]  sat_active;
    logic        sat_overrun;

    always #5 clock = ~clock;

    channel_voice_synth #(
        .HALF_PER0(HP0), .HALF_PER1(HP1), .BURST_LEN(BL), .AMP_INIT(AMP),
        .DECAY_DIV(DD), .DECAY_SHIFT(DS), .SAMPLE_DIV(SD)
    ) dut (
        .clock(clock), .resetn(resetn), .playEn(playEn), .trig(trig),
        .sample(sample), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .active(active), .overrun(overrun)
    );

    channel_voice_synth #(
        .HALF_PER0(HP0), .HALF_PER1(HP1), .BURST_LEN(BL), .AMP_INIT(AMPS),
        .DECAY_DIV(DD), .DECAY_SHIFT(DS), .SAMPLE_DIV(SD)
    ) dut_sat (
        .clock(clock), .resetn(resetn), .playEn(playEn), .trig(sat_trig),
        .sample(sat_sample), .sample_valid(sat_valid), .sample_ready(sat_ready),
        .active(sat_active), .overrun(sat_overrun)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] exp_q [$];
    logic [31:0] sat_q [$];

    // Hand-computed per-sample voice levels for k = 0..7 sample periods into
    // a burst (sample taken at r = 7 + 8k clocks after the burst starts).
    logic signed [31:0] v0 [8];
    logic signed [31:0] v1 [8];
    logic [31:0]        satk [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%0d (0x%08h) required=%0d (0x%08h)",
                      name, $signed(got), got, $signed(want), want);
    endtask

    // Scoreboard monitor: one pop per accepted sample on each instance.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clock);
            if (resetn === 1'b1 && sample_valid && sample_ready) begin
                if (exp_q.size() == 0) begin
                    check("main_unexpected_xfer", sample, 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    $display("main xfer t=%0t sample=%0d expected=%0d", $time, $signed(sample), $signed(e));
                    check("main_sample", sample, e);
                end
            end
            if (resetn === 1'b1 && sat_valid && sat_ready) begin
                if (sat_q.size() == 0) begin
                    check("sat_unexpected_xfer", sat_sample, 32'hDEAD_BEEF);
                end else begin
                    e = sat_q.pop_front();
                    $display("sat  xfer t=%0t sample=0x%08h expected=0x%08h", $time, sat_sample, e);
                    check("sat_sample", sat_sample, e);
                end
            end
        end
    end

    // One sample period (SD clocks), entered 1ns after a period boundary edge.
    // Triggers are driven in the last cycle so they land on the boundary edge.
    task automatic run_period(input logic [1:0] tv, input logic pv, input logic rv,
                              input logic push, input logic [31:0] es,
                              input logic [1:0] ea, input logic ev, input logic eo,
                              input logic [1:0] stv, input logic spush, input logic [31:0] ses);
        playEn       = pv;
        sample_ready = rv;
        trig         = 2'b00;
        sat_trig     = 2'b00;
        if (push)  exp_q.push_back(es);
        if (spush) sat_q.push_back(ses);
        repeat (SD - 1) @(posedge clock);
        #1;
        trig     = tv;
        sat_trig = stv;
        @(negedge clock);
        check("tick_active", {30'd0, active}, {30'd0, ea});
        check("tick_valid", {31'd0, sample_valid}, {31'd0, ev});
        check("tick_overrun", {31'd0, overrun}, {31'd0, eo});
        @(posedge clock);
        #1;
        trig     = 2'b00;
        sat_trig = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        v0   = '{32'sd4096, 32'sd4096, -32'sd4096, -32'sd4096,
                 32'sd3584, 32'sd3584, -32'sd3584, -32'sd3584};
        v1   = '{32'sd4096, -32'sd4096, 32'sd4096, -32'sd4096,
                 32'sd3584, -32'sd3584, 32'sd3584, -32'sd3584};
        satk = '{32'h7FFF_FFFF, 32'h0, 32'h0, 32'h8000_0000,
                 32'h7FFF_FFFF, 32'h0, 32'h0, 32'h8000_0000};

        resetn = 1'b0; playEn = 1'b1; trig = 2'b00; sat_trig = 2'b00;
        sample_ready = 1'b1; sat_ready = 1'b0;

        // Reset held while triggers toggle.
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            trig     = (i % 2 == 0) ? 2'b11 : 2'b00;
            sat_trig = trig;
        end
        @(negedge clock);
        check("reset_sample", sample, 32'd0);
        check("reset_valid", {31'd0, sample_valid}, 32'd0);
        check("reset_active", {30'd0, active}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        @(posedge clock); #1;
        trig = 2'b00; sat_trig = 2'b00; resetn = 1'b1;

        // Single trigger on voice0.
        run_period(2'b00, 1, 1, 1, 32'd0, 2'b00, 0, 0, 2'b00, 0, 32'd0);
        run_period(2'b01, 1, 1, 1, 32'd0, 2'b00, 0, 0, 2'b00, 0, 32'd0);
        check("active_rise_1clk", {30'd0, active}, 32'd1);
        for (int k = 0; k < 8; k++)
            run_period(2'b00, 1, 1, 1, v0[k], 2'b01, 0, 0, 2'b00, 0, 32'd0);
        run_period(2'b00, 1, 1, 1, 32'd0, 2'b00, 0, 0, 2'b00, 0, 32'd0);

        // Dual start, voice0 retriggered half way through.
        run_period(2'b11, 1, 1, 1, 32'd0, 2'b00, 0, 0, 2'b00, 0, 32'd0);
        for (int k = 0; k < 4; k++)
            run_period((k == 3) ? 2'b01 : 2'b00, 1, 1, 1, v0[k] + v1[k], 2'b11, 0, 0, 2'b00, 0, 32'd0);
        for (int k = 0; k < 4; k++)
            run_period(2'b00, 1, 1, 1, v0[k] + v1[k+4], 2'b11, 0, 0, 2'b00, 0, 32'd0);
        for (int k = 4; k < 8; k++)
            run_period(2'b00, 1, 1, 1, v0[k], 2'b01, 0, 0, 2'b00, 0, 32'd0);
        run_period(2'b00, 1, 1, 1, 32'd0, 2'b00, 0, 0, 2'b00, 0, 32'd0);

        // playEn gating: ignored trigger, then playEn dropped mid-burst
        // (including an ignored retrigger attempt).
        run_period(2'b11, 0, 1, 1, 32'd0, 2'b00, 0, 0, 2'b00, 0, 32'd0);
        run_period(2'b00, 0, 1, 1, 32'd0, 2'b00, 0, 0, 2'b00, 0, 32'd0);
        run_period(2'b01, 1, 1, 1, 32'd0, 2'b00, 0, 0, 2'b00, 0, 32'd0);
        for (int k = 0; k < 8; k++)
            run_period((k == 3) ? 2'b01 : 2'b00, 0, 1, 1, v0[k], 2'b01, 0, 0, 2'b00, 0, 32'd0);
        run_period(2'b00, 0, 1, 1, 32'd0, 2'b00, 0, 0, 2'b00, 0, 32'd0);

        // Backpressure for three sample periods.
        run_period(2'b01, 1, 1, 1, 32'd0, 2'b00, 0, 0, 2'b00, 0, 32'd0);
        run_period(2'b00, 1, 1, 1, v0[0], 2'b01, 0, 0, 2'b00, 0, 32'd0);
        for (int k = 1; k < 4; k++) begin
            run_period(2'b00, 1, 0, 0, 32'd0, 2'b01, 1, (k > 1), 2'b00, 0, 32'd0);
            check("held_sample", sample, v0[0]);
            check("held_valid", {31'd0, sample_valid}, 32'd1);
        end
        for (int k = 4; k < 8; k++)
            run_period(2'b00, 1, 1, 1, v0[k], 2'b01, 0, 1, 2'b00, 0, 32'd0);
        run_period(2'b00, 1, 1, 1, 32'd0, 2'b00, 0, 1, 2'b00, 0, 32'd0);

        // Saturation instance: release its long-held idle sample, then burst.
        sat_ready = 1'b1;
        sat_q.push_back(32'd0);
        run_period(2'b00, 1, 1, 1, 32'd0, 2'b00, 0, 1, 2'b11, 1, 32'd0);
        for (int k = 0; k < 8; k++)
            run_period(2'b00, 1, 1, 1, 32'd0, 2'b00, 0, 1, 2'b00, 1, satk[k]);
        run_period(2'b00, 1, 1, 1, 32'd0, 2'b00, 0, 1, 2'b00, 1, 32'd0);

        // Reset in the middle of a burst.
        run_period(2'b01, 1, 1, 1, 32'd0, 2'b00, 0, 1, 2'b00, 1, 32'd0);
        run_period(2'b00, 1, 1, 1, v0[0], 2'b01, 0, 1, 2'b00, 1, 32'd0);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        check("midreset_sample", sample, 32'd0);
        check("midreset_valid", {31'd0, sample_valid}, 32'd0);
        check("midreset_active", {30'd0, active}, 32'd0);
        check("midreset_overrun", {31'd0, overrun}, 32'd0);
        check("midreset_sat_valid", {31'd0, sat_valid}, 32'd0);

        repeat (2) @(posedge clock);
        check("main_queue_drained", exp_q.size(), 32'd0);
        check("sat_queue_drained", sat_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
